audio_clip_sequencer: RTL and testbench

AUDIO_CLIP_SEQUENCER -- requirements
Module: audio_clip_sequencer

---
 rtl/audio_seq_pkg.sv | 40 ++++
 rtl/audio_seq_atten.sv | 27 ++
 rtl/audio_clip_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_audio_clip_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_seq_pkg.sv
// Shared constants for the audio clip sequencer: clip table, state encoding,
// and the position-counter width derived from the longest clip.
package audio_seq_pkg;

    localparam int NUM_CLIPS_DEF = 4;
    localparam int CIDX_W        = (NUM_CLIPS_DEF > 1) ? $clog2(NUM_CLIPS_DEF) : 1;

    // Clip 2 is deliberately empty so a request for it is ignored.
    localparam logic [31:0] CLIP_BASE [NUM_CLIPS_DEF] = '{32'h100, 32'h200, 32'h300, 32'h400};
    localparam logic [31:0] CLIP_LEN  [NUM_CLIPS_DEF] = '{32'd4,   32'd8,   32'd0,   32'd3};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FADE  = 2'd3
    } seq_state_e;

    function automatic int unsigned max_clip_len();
        int unsigned m = 0;
        for (int i = 0; i < NUM_CLIPS_DEF; i++)
            if (CLIP_LEN[CIDX_W'(i)] > m) m = CLIP_LEN[CIDX_W'(i)];
        return m;
    endfunction

    localparam int unsigned MAX_CLIP_LEN = max_clip_len();
    localparam int          POS_W        = $clog2(MAX_CLIP_LEN) + 1;

    // Out-of-table indices read as an empty clip.
    function automatic logic [31:0] clip_len_f(input logic [31:0] idx);
        if (idx < NUM_CLIPS_DEF) return CLIP_LEN[idx[CIDX_W-1:0]];
        return '0;
    endfunction

    function automatic logic [31:0] clip_base_f(input logic [31:0] idx);
        if (idx < NUM_CLIPS_DEF) return CLIP_BASE[idx[CIDX_W-1:0]];
        return '0;
    endfunction

endpackage

// File: rtl/audio_seq_atten.sv
// Registered signed attenuator: arithmetic right shift with the shift amount
// saturated at 15. Output clears whenever no sample is being loaded.
module audio_seq_atten #(
    parameter int SAMPLE_W = 16,
    parameter int SH_W     = 5
) (
    input  logic                       DAC_LR_CLK,
    input  logic                       reset,
    input  logic                       ld_i,
    input  logic signed [SAMPLE_W-1:0] din_i,
    input  logic        [SH_W-1:0]     shamt_i,
    output logic signed [SAMPLE_W-1:0] dout_o
);

    logic        [3:0]          sh_sat;
    logic signed [SAMPLE_W-1:0] dout_q;

    assign sh_sat = (shamt_i > SH_W'(15)) ? 4'd15 : shamt_i[3:0];
    assign dout_o = dout_q;

    // Capture the shifted sample, or return to zero when idle / in reset.
    always_ff @(posedge DAC_LR_CLK) begin
        if (!reset || !ld_i) dout_q <= '0;
        else                 dout_q <= din_i >>> sh_sat;
    end

endmodule

// File: rtl/audio_clip_sequencer.sv
// Frame-rate clip player: walks a ROM address range from the clip table,
// registers attenuated samples to both channels, optionally loops.
// Build option AUDIO_SEQ_FADE_EN: stop fades out over 15 steps of FADE_STEP
// frames instead of cutting immediately.
module audio_clip_sequencer
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int SAMPLE_W   = 16,
    parameter int NUM_CLIPS  = NUM_CLIPS_DEF,
    parameter int CLIP_SEL_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
    parameter int FADE_STEP  = 256
) (
    input  logic                       DAC_LR_CLK,
    input  logic                       reset,
    input  logic                       play_req,
    input  logic                       stop_req,
    input  logic [CLIP_SEL_W-1:0]      clip_sel,
    input  logic                       loop_en,
    input  logic [3:0]                 atten,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic                       rom_rden,
    input  logic signed [SAMPLE_W-1:0] rom_q,
    output logic signed [SAMPLE_W-1:0] sample_l,
    output logic signed [SAMPLE_W-1:0] sample_r,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       done
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, sel_base;
    logic [POS_W-1:0]  pos_q, pos_d, len_q, len_d, sel_len;
    logic              rden_q, rden_d, valid_q, valid_d, done_q, done_d;
    logic              play_ok, start, adv, wrap, ld;
    logic [4:0]        shamt;
    logic signed [SAMPLE_W-1:0] samp;

`ifdef AUDIO_SEQ_FADE_EN
    localparam int FCNT_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    logic [3:0]        fade_q, fade_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    assign shamt = {1'b0, atten} + {1'b0, fade_q};
`else
    assign shamt = {1'b0, atten};
`endif

    assign sel_len  = POS_W'(clip_len_f(32'(clip_sel)));
    assign sel_base = ADDR_W'(clip_base_f(32'(clip_sel)));
    // stop_req always wins over a simultaneous play_req.
    assign play_ok  = play_req && !stop_req && (32'(clip_sel) < 32'(NUM_CLIPS)) && (sel_len != '0);

    // Next-state, address walk, retrigger and end-of-clip handling.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rden_d  = rden_q;
        base_d  = base_q;
        len_d   = len_q;
        pos_d   = pos_q;
        ld      = 1'b0;
        done_d  = 1'b0;
        start   = 1'b0;
        adv     = 1'b0;
        wrap    = loop_en;
`ifdef AUDIO_SEQ_FADE_EN
        fade_d  = fade_q;
        fcnt_d  = fcnt_q;
`endif
        case (state_q)
            ST_IDLE: start = play_ok;
            ST_PLAY, ST_DRAIN: begin
                ld = 1'b1;
                if (stop_req) begin
`ifdef AUDIO_SEQ_FADE_EN
                    state_d = ST_FADE;
                    fade_d  = '0;
                    fcnt_d  = '0;
                    adv     = 1'b1;
                    wrap    = 1'b1;
`else
                    state_d = ST_IDLE;
                    ld      = 1'b0;
                    rden_d  = 1'b0;
`endif
                end else if (play_ok) begin
                    start = 1'b1;
                end else if (state_q == ST_DRAIN) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    adv = 1'b1;
                end
            end
`ifdef AUDIO_SEQ_FADE_EN
            ST_FADE: begin
                ld = 1'b1;
                if (play_ok) begin
                    start = 1'b1;
                end else if (fcnt_q == FCNT_W'(FADE_STEP - 1)) begin
                    fcnt_d = '0;
                    if (fade_q == 4'd14) begin
                        state_d = ST_IDLE;
                        ld      = 1'b0;
                        rden_d  = 1'b0;
                        fade_d  = '0;
                    end else begin
                        fade_d = fade_q + 4'd1;
                        adv    = 1'b1;
                        wrap   = 1'b1;
                    end
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    adv    = 1'b1;
                    wrap   = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d = ST_PLAY;
            addr_d  = sel_base;
            base_d  = sel_base;
            len_d   = sel_len;
            pos_d   = '0;
            rden_d  = 1'b1;
`ifdef AUDIO_SEQ_FADE_EN
            fade_d  = '0;
            fcnt_d  = '0;
`endif
        end else if (adv) begin
            if (pos_q == len_q - POS_W'(1)) begin
                if (wrap) begin
                    addr_d = base_q;
                    pos_d  = '0;
                    rden_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                    rden_d  = 1'b0;
                end
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                pos_d  = pos_q + POS_W'(1);
            end
        end
        valid_d = ld;
    end

    // Sequencer state registers.
    always_ff @(posedge DAC_LR_CLK) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef AUDIO_SEQ_FADE_EN
            fade_q  <= '0;
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            base_q  <= base_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef AUDIO_SEQ_FADE_EN
            fade_q  <= fade_d;
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    audio_seq_atten #(.SAMPLE_W(SAMPLE_W), .SH_W(5)) u_atten (
        .DAC_LR_CLK (DAC_LR_CLK),
        .reset      (reset),
        .ld_i       (ld),
        .din_i      (rom_q),
        .shamt_i    (shamt),
        .dout_o     (samp)
    );

    assign sample_l     = samp;
    assign sample_r     = samp;
    assign rom_addr     = addr_q;
    assign rom_rden     = rden_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Scoreboard bench for audio_clip_sequencer: stimulus pushes expected
// {sample, done} per output frame; a negedge monitor pops and compares.
module tb_audio_clip_sequencer;

    logic        clk = 1'b0;
    logic        reset, play_req, stop_req, loop_en;
    logic [1:0]  clip_sel;
    logic [3:0]  atten;
    logic [17:0] rom_addr;
    logic        rom_rden, sv, busy, done;
    logic [15:0] rom_q, sl, sr;
    logic        mon_en = 1'b1;
    int          n_tests = 0, n_fail = 0;

    typedef struct { logic [15:0] s; logic d; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    audio_clip_sequencer #(.FADE_STEP(2)) dut (
        .DAC_LR_CLK(clk), .reset(reset), .play_req(play_req), .stop_req(stop_req),
        .clip_sel(clip_sel), .loop_en(loop_en), .atten(atten),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
        .sample_l(sl), .sample_r(sr), .sample_valid(sv), .busy(busy), .done(done)
    );

    // ROM model: data = low address bits, with a few signed test words.
    always_comb begin
        case (rom_addr)
            18'h400: rom_q = 16'h8000;
            18'h401: rom_q = 16'h7FFF;
            18'h402: rom_q = 16'h1234;
            default: rom_q = 16'(rom_addr);
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [15:0] s, input logic d);
        exp_t e;
        e.s = s; e.d = d;
        sb.push_back(e);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(sv), 0);
        chk({tag, "_sample"}, 32'(sl), 0);
        chk({tag, "_rden"}, 32'(rom_rden), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Monitor: every frame the DUT presents data or done, compare with the next expectation.
    always @(negedge clk) begin
        if (mon_en && (sv || done)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got sample %h done %b, expected no output", sl, done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_sample_l", 32'(sl), 32'(e.s));
                chk("mon_sample_r", 32'(sr), 32'(e.s));
                chk("mon_done", 32'(done), 32'(e.d));
                chk("mon_valid", 32'(sv), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; play_req = 1'b0; stop_req = 1'b0; loop_en = 1'b0;
        clip_sel = 2'd0; atten = 4'd0;
        tick(2);
        idle_chk("reset");
        chk("reset_addr", 32'(rom_addr), 0);
        reset = 1'b1;
        tick();

        // One-shot clip 0: 0x100..0x103, then done with busy falling.
        clip_sel = 2'd0; play_req = 1'b1;
        push(16'h100, 0); push(16'h101, 0); push(16'h102, 0); push(16'h103, 0); push(16'h103, 1);
        tick();
        play_req = 1'b0;
        chk("t1_addr", 32'(rom_addr), 32'h100);
        chk("t1_rden", 32'(rom_rden), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_valid0", 32'(sv), 0);
        tick(4);
        chk("t1_busy_before_done", 32'(busy), 1);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_with_done", 32'(busy), 0);
        tick();
        idle_chk("t1_after");

        // Looping clip 0 for 10 frames, then drop loop_en mid-clip.
        loop_en = 1'b1; play_req = 1'b1;
        for (int i = 0; i < 10; i++) push(16'h100 + 16'(i % 4), 0);
        push(16'h102, 0); push(16'h103, 0); push(16'h103, 1);
        tick();
        play_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_no_gap", 32'(sv), 1);
            chk("t2_no_done", 32'(done), 0);
        end
        loop_en = 1'b0;
        tick(3);
        chk("t2_done", 32'(done), 1);
        tick();
        idle_chk("t2_after");

        // Signed attenuation, changed every frame on clip 3.
        clip_sel = 2'd3; atten = 4'd4; play_req = 1'b1;
        push(16'hF800, 0); push(16'h0000, 0); push(16'h048D, 0); push(16'h1234, 1);
        tick();
        play_req = 1'b0;
        tick();
        atten = 4'd15;
        tick();
        atten = 4'd2;
        tick();
        atten = 4'd0;
        tick();
        chk("t3_done", 32'(done), 1);
        tick();
        idle_chk("t3_after");

        // Retrigger clip 1 -> clip 0 mid-play: no done for the abandoned clip.
        clip_sel = 2'd1; play_req = 1'b1;
        push(16'h200, 0); push(16'h201, 0); push(16'h202, 0);
        push(16'h100, 0); push(16'h101, 0); push(16'h102, 0); push(16'h103, 0); push(16'h103, 1);
        tick();
        play_req = 1'b0;
        tick(2);
        clip_sel = 2'd0; play_req = 1'b1;
        tick();
        play_req = 1'b0;
        chk("t4_retrig_addr", 32'(rom_addr), 32'h100);
        chk("t4_no_done", 32'(done), 0);
        tick(5);
        chk("t4_done", 32'(done), 1);
        tick();
        idle_chk("t4_after");

        // Empty clip request is ignored.
        clip_sel = 2'd2; play_req = 1'b1;
        tick();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_rden", 32'(rom_rden), 0);
        play_req = 1'b0;
        tick();
        chk("t5_busy2", 32'(busy), 0);

        // stop_req together with play_req at frame 2 of clip 1: stop wins.
        clip_sel = 2'd1; play_req = 1'b1;
        push(16'h200, 0); push(16'h201, 0);
        tick();
        play_req = 1'b0;
        tick(2);
`ifndef AUDIO_SEQ_FADE_EN
        clip_sel = 2'd0; play_req = 1'b1; stop_req = 1'b1;
        tick();
        play_req = 1'b0; stop_req = 1'b0;
        idle_chk("t6_stop");
        tick(3);
        idle_chk("t6_stop_late");
`else
        mon_en = 1'b0;
        clip_sel = 2'd0; play_req = 1'b1; stop_req = 1'b1;
        tick();
        play_req = 1'b0; stop_req = 1'b0;
        chk("t6_fade_busy", 32'(busy), 1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("t6_fade_frames", 32'(n), 30);
        idle_chk("t6_fade_end");
        mon_en = 1'b1;
`endif

        // Reset mid-clip, then a clean restart.
        clip_sel = 2'd0; play_req = 1'b1;
        push(16'h100, 0); push(16'h101, 0);
        tick();
        play_req = 1'b0;
        tick(2);
        reset = 1'b0;
        tick();
        idle_chk("t7_reset");
        chk("t7_reset_addr", 32'(rom_addr), 0);
        reset = 1'b1; play_req = 1'b1;
        push(16'h100, 0); push(16'h101, 0); push(16'h102, 0); push(16'h103, 0); push(16'h103, 1);
        tick();
        play_req = 1'b0;
        chk("t7_addr", 32'(rom_addr), 32'h100);
        chk("t7_rden", 32'(rom_rden), 1);
        chk("t7_valid0", 32'(sv), 0);
        tick(5);
        chk("t7_done", 32'(done), 1);
        tick();
        idle_chk("t7_after");

        tick(2);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
